// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient loader: FSM states, coefficient type, checksum helper.
package fir_pkg;

  localparam int unsigned COEF_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } loader_state_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Running checksum step; caller truncates the result to its coefficient width.
  function automatic logic [31:0] coef_checksum(input logic [31:0] acc, input logic [31:0] beat);
    return acc + beat;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow + active coefficient register pair: indexed writes into shadow,
// whole-bank copy to active on a single commit strobe.
module fir_coef_bank #(
  parameter int unsigned TAPS       = 100,
  parameter int unsigned COEF_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic [$clog2(TAPS)-1:0]      i_wr_idx,
  input  logic signed [COEF_WIDTH-1:0] i_wr_data,
  input  logic                         i_commit,
  output logic signed [COEF_WIDTH-1:0] o_coef [0:TAPS-1]
);

  localparam int unsigned IDX_W = $clog2(TAPS);

  logic signed [COEF_WIDTH-1:0] r_shadow [0:TAPS-1];

  // Shadow bank: one entry written per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAPS); i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < int'(TAPS); i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) r_shadow[i] <= i_wr_data;
      end
    end
  end

  // Active bank: the filter only ever sees a complete set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAPS); i++) o_coef[i] <= '0;
    end else if (i_commit) begin
      for (int i = 0; i < int'(TAPS); i++) o_coef[i] <= r_shadow[i];
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Serial loader for the FIR coefficient array with atomic commit to the active bank.
// Optional COEF_CHECKSUM_EN adds a trailing checksum beat that gates the commit.
module fir_coef_loader #(
  parameter int unsigned TAPS       = 100,
  parameter int unsigned COEF_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         s_valid,
  input  logic [COEF_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic signed [COEF_WIDTH-1:0] coef [0:TAPS-1],
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  import fir_pkg::*;

  localparam int unsigned     IDX_W    = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  loader_state_e    r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_wr_en;
  logic             w_commit;
  logic             w_beat;
`ifdef COEF_CHECKSUM_EN
  logic                  r_err, w_err_nxt;
  logic [COEF_WIDTH-1:0] r_sum, w_sum_nxt;
`endif

  assign w_beat = s_valid && r_ready;

  // Next-state, write strobes and registered-output next values
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
`ifdef COEF_CHECKSUM_EN
    w_err_nxt   = 1'b0;
    w_sum_nxt   = r_sum;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
`ifdef COEF_CHECKSUM_EN
          w_sum_nxt   = '0;
`endif
        end
      end
      LOAD: begin
        if (start) begin
          w_idx_nxt = '0;
`ifdef COEF_CHECKSUM_EN
          w_sum_nxt = '0;
`endif
        end else if (w_beat) begin
          w_wr_en = 1'b1;
`ifdef COEF_CHECKSUM_EN
          w_sum_nxt = COEF_WIDTH'(coef_checksum(32'(r_sum), 32'(s_data)));
`endif
          if (r_idx == LAST_IDX) begin
`ifdef COEF_CHECKSUM_EN
            w_state_nxt = CHECK;
`else
            w_state_nxt = COMMIT;
`endif
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
`ifdef COEF_CHECKSUM_EN
      CHECK: begin
        if (start) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
          w_sum_nxt   = '0;
        end else if (w_beat) begin
          if (s_data == r_sum) begin
            w_state_nxt = COMMIT;
          end else begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
          end
        end
      end
`endif
      COMMIT: begin
        w_commit   = 1'b1;
        w_done_nxt = 1'b1;
        if (start) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
`ifdef COEF_CHECKSUM_EN
          w_sum_nxt   = '0;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == LOAD) || (w_state_nxt == CHECK);
    w_busy_nxt  = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef COEF_CHECKSUM_EN
      r_err   <= 1'b0;
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef COEF_CHECKSUM_EN
      r_err   <= w_err_nxt;
      r_sum   <= w_sum_nxt;
`endif
    end
  end

  assign s_ready = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
`ifdef COEF_CHECKSUM_EN
  assign err     = r_err;
`else
  assign err     = 1'b0;
`endif

  fir_coef_bank #(
    .TAPS       (TAPS),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data ($signed(s_data)),
    .i_commit  (w_commit),
    .o_coef    (coef)
  );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed/randomized bench for fir_coef_loader against an array-level model of the active bank.
module tb_fir_coef_loader;

  localparam int unsigned TAPS = 100;
  localparam int unsigned W    = 16;
`ifdef COEF_CHECKSUM_EN
  localparam int NB = TAPS + 1;
`else
  localparam int NB = TAPS;
`endif

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data  = '0;
  logic         s_ready, busy, done, err;
  logic signed [W-1:0] coef [0:TAPS-1];

  logic signed [W-1:0] cur       [TAPS];
  logic signed [W-1:0] model_act [TAPS];
  logic [W-1:0]        cks_delta = '0;
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fir_coef_loader #(.TAPS(TAPS), .COEF_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .coef    (coef),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_bad();
    int n = 0;
    for (int i = 0; i < int'(TAPS); i++) if (coef[i] !== model_act[i]) n++;
    return n;
  endfunction

  // Beat k of the current set; beat TAPS is the checksum when enabled
  function automatic logic [W-1:0] beat_data(input int k);
    logic [W-1:0] s;
    if (k < int'(TAPS)) return cur[k];
    s = cks_delta;
    for (int i = 0; i < int'(TAPS); i++) s = s + W'(cur[i]);
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < int'(TAPS); i++) model_act[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(s_ready), 32'd1);
  endtask

  // Stream n beats with valid asserted pct% of cycles; active bank must not move
  task automatic stream_beats(input int n, input int pct);
    int acc = 0, cyc = 0, ndone = 0, nerr = 0, nbad = 0;
    logic rdy;
    while (acc < n && cyc < 4000) begin
      s_valid = ($urandom_range(99) < 32'(pct));
      s_data  = beat_data(acc);
      rdy     = s_ready;
      @(posedge clk); #1;
      cyc++;
      if (s_valid && rdy) acc++;
      if (done) ndone++;
      if (err && acc < n) nerr++;
      if (count_bad() != 0) nbad++;
    end
    s_valid = 1'b0;
    chk("stream_timeout", 32'(acc), 32'(n));
    chk("stream_no_done", 32'(ndone), 32'd0);
    chk("stream_no_err", 32'(nerr), 32'd0);
    chk("stream_coef_stable", 32'(nbad), 32'd0);
  endtask

  task automatic load_set(input int pct, input bit restart);
    stream_beats(NB, pct);
    chk("pre_commit_done", 32'(done), 32'd0);
    chk("pre_commit_busy", 32'(busy), 32'd1);
    chk("pre_commit_ready", 32'(s_ready), 32'd0);
    chk("pre_commit_coef", 32'(count_bad()), 32'd0);
    start = restart;
    @(posedge clk); #1;
    start = 1'b0;
    model_act = cur;
    chk("commit_done", 32'(done), 32'd1);
    chk("commit_coef_all", 32'(count_bad()), 32'd0);
    chk("commit_coef0", 32'(coef[0]), 32'(model_act[0]));
    chk("commit_coef_last", 32'(coef[TAPS-1]), 32'(model_act[TAPS-1]));
    chk("commit_err", 32'(err), 32'd0);
    if (restart) begin
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_ready", 32'(s_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
      chk("post_done_low", 32'(done), 32'd0);
      chk("post_busy_low", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    // 1: reset state, then back-to-back load of i+1
    do_reset();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_coef", 32'(count_bad()), 32'd0);
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'(i + 1);
    pulse_start();
    load_set(100, 1'b0);
    chk("t1_coef0_is_1", 32'(coef[0]), 32'd1);
    chk("t1_coef99_is_100", 32'(coef[TAPS-1]), 32'd100);

    // 2: gappy stream of i*-3 from a fresh reset; bank stays zero until commit
    do_reset();
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'(-3 * i);
    pulse_start();
    load_set(70, 1'b0);

    // 3: abort set A after 40 beats; beat coincident with restart is dropped
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'($urandom);
    pulse_start();
    stream_beats(40, 100);
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'($urandom);
    start = 1'b1; s_valid = 1'b1; s_data = 16'h7777;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_ready", 32'(s_ready), 32'd1);
    load_set(80, 1'b0);

    // 4: asynchronous reset mid-load clears the active bank immediately
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'($urandom);
    pulse_start();
    stream_beats(60, 100);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < int'(TAPS); i++) model_act[i] = '0;
    chk("async_rst_ready", 32'(s_ready), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_coef", 32'(count_bad()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'($urandom);
    pulse_start();
    load_set(90, 1'b0);

`ifdef COEF_CHECKSUM_EN
    // 5: checksum match commits, off-by-one checksum is rejected
    for (int i = 0; i < int'(TAPS); i++) cur[i] = 16'sh0001;
    cks_delta = '0;
    chk("cks_value", 32'(beat_data(TAPS)), 32'h64);
    pulse_start();
    load_set(100, 1'b0);
    cks_delta = 16'hFFFF;
    pulse_start();
    stream_beats(NB, 100);
    chk("cks_err_pulse", 32'(err), 32'd1);
    chk("cks_err_done", 32'(done), 32'd0);
    chk("cks_err_coef", 32'(count_bad()), 32'd0);
    @(posedge clk); #1;
    chk("cks_err_low", 32'(err), 32'd0);
    chk("cks_err_idle", 32'(busy), 32'd0);
    chk("cks_err_no_done", 32'(done), 32'd0);
    cks_delta = '0;
`endif

    // 6: start during COMMIT chains straight into the next load
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'($urandom);
    pulse_start();
    load_set(100, 1'b1);
    for (int i = 0; i < int'(TAPS); i++) cur[i] = W'($urandom);
    load_set(60, 1'b0);
    chk("final_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
